spi_pin_conditioner: RTL and testbench
======================================

Name: spi_pin_conditioner

Overview:
- Front-end stage ahead of the SPI fsm.
- Takes the raw asynchronous SPI pins (SCLK, CS, MOSI) and, per pin:
  - synchronizes it into the clk domain,
  - rejects glitches shorter than a programmable width,
  - produces clean levels plus single-cycle rising/falling-edge pulses.
- The fsm consumes cs_clean, sclk_posedge/sclk_negedge and mosi_clean instead of raw pins.

Parameters:
- N_STAGES, 2, synchronizer flop depth per channel (≥2).
- DEBOUNCE_CNT, 3, consecutive clk cycles a new synced level must persist before it is accepted (≥1; 1 = no filtering).
- CNT_W, 4, debounce counter width; requires DEBOUNCE_CNT ≤ 2^CNT_W.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- sclk_pin  input  1  raw SPI clock pin, asynchronous
- cs_pin  input  1  raw chip select pin, active low, asynchronous
- mosi_pin  input  1  raw MOSI pin, asynchronous
- sclk_clean  output  1  conditioned SCLK level
- sclk_posedge  output  1  one-cycle pulse when sclk_clean goes 0→1
- sclk_negedge  output  1  one-cycle pulse when sclk_clean goes 1→0
- cs_clean  output  1  conditioned CS level
- cs_fall  output  1  one-cycle pulse when cs_clean goes 1→0 (frame start)
- cs_rise  output  1  one-cycle pulse when cs_clean goes 0→1 (frame end)
- mosi_clean  output  1  conditioned MOSI level
- glitch_cnt  output  8  rejected-glitch count (see Optional Feature)

Behaviour:
- Channels: three identical channel instances (sclk, cs, mosi), independent, no cross-channel interaction except glitch_cnt.
- Reset: rst_n low asynchronously forces all channel state to idle level: sclk 0, cs 1, mosi 0.
  - Idle level applies to every sync flop and the clean level.
  - Debounce counters go to 0; all edge pulses 0; glitch_cnt 0.
  - Outputs after reset: sclk_clean=0, cs_clean=1, mosi_clean=0, all pulses 0.
  - Reset deassertion is sampled synchronously by the rising clk edge (no pulse generated on release).
- Synchronizer: N_STAGES-flop shift chain; the last stage is sync_out.
- Debounce per edge:
  - sync_out == clean: cnt ← 0.
  - sync_out != clean and cnt < DEBOUNCE_CNT-1: cnt ← cnt+1.
  - sync_out != clean and cnt == DEBOUNCE_CNT-1: clean ← sync_out, cnt ← 0, and the matching edge pulse is registered on the same edge.
  - Net effect: the pulse is high exactly one cycle, coincident with the first cycle of the new clean level.
- Latency: counting the first clk edge that samples the new pin level as edge 1, clean changes and the pulse asserts on edge N_STAGES+DEBOUNCE_CNT (defaults: edge 5).
  - A level held fewer than DEBOUNCE_CNT cycles at sync_out never reaches clean.
- Glitch definition: sync_out returns to clean while cnt != 0. The counter clears and the event is a rejected glitch.
- Edge pulses:
  - Posedge and negedge of one channel are mutually exclusive.
  - Back-to-back opposite edges are separated by at least DEBOUNCE_CNT cycles.
  - Pulses on different channels may coincide (e.g. cs_fall with sclk_negedge).
- Simultaneous events: channels update independently on the same edge; no priority.
- Reset mid-operation: in-progress debounce is discarded; outputs return to idle immediately (asynchronously).
- DEBOUNCE_CNT=1: clean follows sync_out with one register delay; glitches are never counted.

Optional Feature:
- Macro: SPI_GLITCH_COUNT_EN.
- Defined:
  - glitch_cnt is an 8-bit counter, incremented on each edge by the number of channels rejecting a glitch that cycle (0–3).
  - Saturates at 255; cleared only by rst_n.
- Undefined: glitch_cnt is tied to 0 and no counter logic is built. Port is present in both builds.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, pins idle, release → sclk_clean=0, cs_clean=1, mosi_clean=0, no pulses for 10 cycles; asserting rst_n mid-frame returns cs_clean to 1 without waiting for clk.
- Latency: defaults; drive cs_pin 1→0 just before edge 1 → cs_clean=0 and cs_fall=1 on edge 5 only; cs_fall=0 on edge 6.
- Glitch rejection: sclk_pin high for 2 clk cycles then low → sclk_clean stays 0, no sclk_posedge; with SPI_GLITCH_COUNT_EN, glitch_cnt=1. Repeat with 3-cycle high → sclk_posedge fires; glitch_cnt unchanged.
- SPI frame: cs_pin low, 8 SCLK periods of 20 clk cycles, MOSI=0xA5 changed on SCLK falling → exactly 8 sclk_posedge pulses; mosi_clean at each pulse reads 1,0,1,0,0,1,0,1; one cs_fall, one cs_rise.
- Simultaneous: glitch of 1 cycle on all three pins on the same edge → glitch_cnt +3 in one cycle; force count to 254 then repeat → saturates at 255.
- Macro off: rerun glitch scenario without SPI_GLITCH_COUNT_EN → glitch_cnt=0 throughout; all other outputs identical to macro-on run.

Source files
------------

// File: rtl/spi_pin_conditioner.sv
// spi_pin_conditioner: front end for the SPI fsm. Each raw, asynchronous SPI pin
// (sclk, cs, mosi) is synchronized into the clk domain, glitch filtered, and
// presented as a clean level plus single-cycle edge pulses.
//
// Optional build macro: SPI_GLITCH_COUNT_EN. When defined, glitch_cnt counts
// rejected glitches (saturating at 255). When undefined, glitch_cnt is tied to 0.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   sclk_pin      raw SPI clock pin
//   cs_pin        raw chip select pin (active low)
//   mosi_pin      raw MOSI pin
//   sclk_clean    conditioned SCLK level
//   sclk_posedge  one-cycle pulse when sclk_clean goes 0->1
//   sclk_negedge  one-cycle pulse when sclk_clean goes 1->0
//   cs_clean      conditioned CS level
//   cs_fall       one-cycle pulse when cs_clean goes 1->0 (frame start)
//   cs_rise       one-cycle pulse when cs_clean goes 0->1 (frame end)
//   mosi_clean    conditioned MOSI level
//   glitch_cnt    rejected-glitch count
module spi_pin_conditioner #(
    parameter int unsigned N_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CNT = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       sclk_clean,
    output logic       sclk_posedge,
    output logic       sclk_negedge,
    output logic       cs_clean,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic       mosi_clean,
    output logic [7:0] glitch_cnt
);

    localparam int unsigned NCH = 3;
    // Channel order: 0 = sclk, 1 = cs, 2 = mosi. Idle levels: sclk 0, cs 1, mosi 0.
    localparam logic [NCH-1:0] IDLE_LVL = 3'b010;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [NCH-1:0]                pins;
    logic [NCH-1:0][N_STAGES-1:0]  sync_q;
    logic [NCH-1:0][CNT_W-1:0]     cnt_q;
    logic [NCH-1:0]                clean_q;
    logic [NCH-1:0]                sync_out;
    logic [NCH-1:0]                accept;
    // Edge pulses are only needed for sclk and cs.
    logic [1:0]                    rise_q;
    logic [1:0]                    fall_q;

    assign pins = {mosi_pin, cs_pin, sclk_pin};

    always_comb begin
        sync_out = '0;
        accept   = '0;
        for (int c = 0; c < NCH; c++) begin
            sync_out[c] = sync_q[c][N_STAGES-1];
            // New level has persisted DEBOUNCE_CNT cycles: take it this edge.
            accept[c]   = (sync_out[c] != clean_q[c]) && (cnt_q[c] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                sync_q[c] <= {N_STAGES{IDLE_LVL[c]}};
            end
            cnt_q   <= '0;
            clean_q <= IDLE_LVL;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                sync_q[c] <= {sync_q[c][N_STAGES-2:0], pins[c]};
                if (sync_out[c] == clean_q[c]) begin
                    cnt_q[c] <= '0;
                end else if (accept[c]) begin
                    clean_q[c] <= sync_out[c];
                    cnt_q[c]   <= '0;
                end else begin
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                end
            end
            // Pulse is registered alongside clean, so it marks the first new-level cycle.
            for (int c = 0; c < 2; c++) begin
                rise_q[c] <= accept[c] & sync_out[c];
                fall_q[c] <= accept[c] & ~sync_out[c];
            end
        end
    end

    assign sclk_clean   = clean_q[0];
    assign sclk_posedge = rise_q[0];
    assign sclk_negedge = fall_q[0];
    assign cs_clean     = clean_q[1];
    assign cs_fall      = fall_q[1];
    assign cs_rise      = rise_q[1];
    assign mosi_clean   = clean_q[2];

`ifdef SPI_GLITCH_COUNT_EN
    logic [NCH-1:0] glitch;
    logic [8:0]     glitch_sum;
    logic [7:0]     glitch_q;

    always_comb begin
        glitch = '0;
        // A glitch is a return to the clean level before the debounce count completed.
        for (int c = 0; c < NCH; c++) begin
            glitch[c] = (sync_out[c] == clean_q[c]) && (cnt_q[c] != '0);
        end
        glitch_sum = {1'b0, glitch_q} + 9'(glitch[0]) + 9'(glitch[1]) + 9'(glitch[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_pin_conditioner.sv
// Self-checking bench for spi_pin_conditioner. Edge pulses are predicted from the
// stimulus (pin change cycle + synchronizer depth + debounce length) and queued;
// a negedge monitor matches every observed pulse against that queue.
module tb_spi_pin_conditioner;

    localparam int N_STAGES     = 2;
    localparam int DEBOUNCE_CNT = 3;
    localparam int LAT          = N_STAGES + DEBOUNCE_CNT;

`ifdef SPI_GLITCH_COUNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    localparam int KSclkPos = 0;
    localparam int KSclkNeg = 1;
    localparam int KCsFall  = 2;
    localparam int KCsRise  = 3;

    typedef struct {
        int kind;
        int at;
        bit mosi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk_pin, cs_pin, mosi_pin;
    logic       sclk_clean, sclk_posedge, sclk_negedge;
    logic       cs_clean, cs_fall, cs_rise, mosi_clean;
    logic [7:0] glitch_cnt;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pulse[4];
    int   gc_model = 0;
    exp_t sb[$];
    logic [3:0] pulses;
    int   idx;
    logic [7:0] frame_byte;

    spi_pin_conditioner #(
        .N_STAGES    (N_STAGES),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_pin    (sclk_pin),
        .cs_pin      (cs_pin),
        .mosi_pin    (mosi_pin),
        .sclk_clean  (sclk_clean),
        .sclk_posedge(sclk_posedge),
        .sclk_negedge(sclk_negedge),
        .cs_clean    (cs_clean),
        .cs_fall     (cs_fall),
        .cs_rise     (cs_rise),
        .mosi_clean  (mosi_clean),
        .glitch_cnt  (glitch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input bit m);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        e.mosi = m;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int exp_gc();
        return GC_EN ? gc_model : 0;
    endfunction

    function automatic void add_glitches(input int n);
        gc_model = (gc_model + n > 255) ? 255 : gc_model + n;
    endfunction

    // Pulse monitor / scoreboard consumer.
    always @(negedge clk) begin
        pulses = {cs_rise, cs_fall, sclk_negedge, sclk_posedge};
        for (int k = 0; k < 4; k++) begin
            if (pulses[k]) begin
                n_pulse[k]++;
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (idx < 0 && sb[i].kind == k) idx = i;
                end
                if (idx < 0) begin
                    check("unexpected_pulse_kind", k, 99);
                end else begin
                    check("pulse_cycle", cyc, sb[idx].at);
                    if (k == KSclkPos) check("mosi_at_sclk_pos", mosi_clean, sb[idx].mosi);
                    sb.delete(idx);
                end
            end
        end
    end

    // Drive all three pins away from idle for one cycle.
    task automatic triple_glitch();
        sclk_pin = 1'b1;
        cs_pin   = 1'b0;
        mosi_pin = 1'b1;
        step(1);
        sclk_pin = 1'b0;
        cs_pin   = 1'b1;
        mosi_pin = 1'b0;
        step(6);
        add_glitches(3);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) n_pulse[k] = 0;
        rst_n    = 1'b0;
        sclk_pin = 1'b0;
        cs_pin   = 1'b1;
        mosi_pin = 1'b0;

        // Reset and idle.
        step(3);
        check("reset_levels", {sclk_clean, cs_clean, mosi_clean}, 3'b010);
        check("reset_glitch_cnt", glitch_cnt, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("idle_levels", {sclk_clean, cs_clean, mosi_clean}, 3'b010);
        end

        // Latency on cs fall.
        cs_pin = 1'b0;
        push(KCsFall, cyc + LAT, 1'b0);
        step(LAT - 1);
        check("cs_clean_before_lat", cs_clean, 1);
        check("cs_fall_before_lat", cs_fall, 0);
        step(1);
        check("cs_clean_at_lat", cs_clean, 0);
        check("cs_fall_at_lat", cs_fall, 1);
        step(1);
        check("cs_fall_after_lat", cs_fall, 0);
        check("cs_clean_after_lat", cs_clean, 0);

        // Asynchronous reset mid-frame.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_cs", cs_clean, 1);
        check("async_reset_sclk_mosi", {sclk_clean, mosi_clean}, 0);
        cs_pin = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(LAT + 3);
        check("post_reset_levels", {sclk_clean, cs_clean, mosi_clean}, 3'b010);

        // Two-cycle sclk pulse is rejected.
        sclk_pin = 1'b1;
        step(2);
        sclk_pin = 1'b0;
        step(6);
        add_glitches(1);
        check("glitch2_sclk_clean", sclk_clean, 0);
        check("glitch2_cnt", glitch_cnt, exp_gc());

        // Three-cycle sclk pulse is accepted.
        sclk_pin = 1'b1;
        push(KSclkPos, cyc + LAT, 1'b0);
        step(3);
        check("pulse3_sclk_clean", sclk_clean, 0);
        sclk_pin = 1'b0;
        push(KSclkNeg, cyc + LAT, 1'b0);
        step(LAT + 2);
        check("pulse3_cnt_unchanged", glitch_cnt, exp_gc());
        check("pulse3_sclk_clean_end", sclk_clean, 0);

        // Simultaneous one-cycle glitch on all pins: +3 on a single edge.
        sclk_pin = 1'b1;
        cs_pin   = 1'b0;
        mosi_pin = 1'b1;
        step(1);
        sclk_pin = 1'b0;
        cs_pin   = 1'b1;
        mosi_pin = 1'b0;
        step(2);
        check("triple_before", glitch_cnt, exp_gc());
        step(1);
        add_glitches(3);
        check("triple_after", glitch_cnt, exp_gc());
        check("triple_levels", {sclk_clean, cs_clean, mosi_clean}, 3'b010);
        step(4);

        // Saturation: climb to 253, one more glitch to 254, then saturate.
        while (gc_model + 3 < 255) triple_glitch();
        check("gc_253", glitch_cnt, exp_gc());
        sclk_pin = 1'b1;
        step(1);
        sclk_pin = 1'b0;
        step(6);
        add_glitches(1);
        check("gc_254", glitch_cnt, exp_gc());
        triple_glitch();
        check("gc_saturate", glitch_cnt, exp_gc());
        triple_glitch();
        check("gc_hold_255", glitch_cnt, exp_gc());

        // SPI frame: 0xA5, MOSI changes on SCLK falling, 20-cycle SCLK period.
        for (int k = 0; k < 4; k++) n_pulse[k] = 0;
        frame_byte = 8'hA5;
        cs_pin = 1'b0;
        push(KCsFall, cyc + LAT, 1'b0);
        step(10);
        for (int b = 7; b >= 0; b--) begin
            mosi_pin = frame_byte[b];
            step(10);
            sclk_pin = 1'b1;
            push(KSclkPos, cyc + LAT, frame_byte[b]);
            step(10);
            sclk_pin = 1'b0;
            push(KSclkNeg, cyc + LAT, 1'b0);
        end
        mosi_pin = 1'b0;
        step(10);
        cs_pin = 1'b1;
        push(KCsRise, cyc + LAT, 1'b0);
        step(LAT + 5);
        check("frame_sclk_pos_count", n_pulse[KSclkPos], 8);
        check("frame_sclk_neg_count", n_pulse[KSclkNeg], 8);
        check("frame_cs_fall_count", n_pulse[KCsFall], 1);
        check("frame_cs_rise_count", n_pulse[KCsRise], 1);
        check("frame_end_levels", {sclk_clean, cs_clean, mosi_clean}, 3'b010);
        check("frame_gc_unchanged", glitch_cnt, exp_gc());
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
